// File: rtl/cpu_pkg.sv
// Shared core types: default table geometry, register index / ROB tag typedefs
// and the per-register status record.
package cpu_pkg;

    localparam int unsigned NREG_DEFAULT = 32;
    localparam int unsigned TAGW_DEFAULT = 5;

    typedef logic [$clog2(NREG_DEFAULT)-1:0] reg_idx_t;
    typedef logic [TAGW_DEFAULT-1:0]         rob_tag_t;

    typedef struct packed {
        logic     busy;
        rob_tag_t tag;
    } status_entry_t;

endpackage

// File: rtl/rst_lookup.sv
// One combinational read port of the register status table, including the
// same-cycle commit bypass and the hardwired-zero register.
module rst_lookup #(
    parameter  int unsigned NREG     = 32,
    parameter  int unsigned TAGW     = 5,
    parameter  int unsigned ZERO_REG = 1,
    localparam int unsigned IDXW     = $clog2(NREG)
) (
    input  logic [IDXW-1:0]            idx,
    input  logic [NREG-1:0]            busy_vec,
    input  logic [NREG-1:0][TAGW-1:0]  tag_vec,
    input  logic                       cmt_valid,
    input  logic [IDXW-1:0]            cmt_idx,
    input  logic [TAGW-1:0]            cmt_tag,
    output logic                       busy,
    output logic [TAGW-1:0]            tag
);

    logic            w_busy;
    logic [TAGW-1:0] w_tag;
    logic            w_bypass;
    logic            w_zero;

    always_comb begin
        w_busy   = busy_vec[idx];
        w_tag    = tag_vec[idx];
        // A committing producer releases the register in the cycle it retires.
        w_bypass = cmt_valid && (cmt_idx == idx) && (w_tag == cmt_tag) && w_busy;
        w_zero   = (ZERO_REG != 0) && (idx == '0);
        busy     = w_busy && !w_bypass && !w_zero;
        tag      = busy ? w_tag : '0;
    end

endmodule

// File: rtl/reg_status_table.sv
// Register result-status table: per-register pending bit and producing ROB tag,
// renamed at dispatch, cleared by tag-matched commit or a full flush.
module reg_status_table
    import cpu_pkg::*;
#(
    parameter  int unsigned NREG     = NREG_DEFAULT,
    parameter  int unsigned TAGW     = TAGW_DEFAULT,
    parameter  int unsigned ZERO_REG = 1,
    localparam int unsigned IDXW     = $clog2(NREG),
    localparam int unsigned CNTW     = IDXW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDXW-1:0]   src1_idx,
    input  logic [IDXW-1:0]   src2_idx,
    output logic              src1_busy,
    output logic [TAGW-1:0]   src1_tag,
    output logic              src2_busy,
    output logic [TAGW-1:0]   src2_tag,
    input  logic              ren_valid,
    input  logic [IDXW-1:0]   ren_idx,
    input  logic [TAGW-1:0]   ren_tag,
    input  logic              cmt_valid,
    input  logic [IDXW-1:0]   cmt_idx,
    input  logic [TAGW-1:0]   cmt_tag,
    input  logic              flush,
    input  logic [IDXW-1:0]   probe_idx,
    output logic              probe_busy,
    output logic [TAGW-1:0]   probe_tag,
    output logic [CNTW-1:0]   busy_count
);

    logic [NREG-1:0]           r_busy;
    logic [NREG-1:0][TAGW-1:0] r_tag;
    logic [CNTW-1:0]           r_busy_count;

    logic            w_ren_ok;
    logic            w_ren_new;
    logic            w_cmt_hit;
    logic            w_cmt_clr;
    logic [CNTW-1:0] w_count_nxt;

    // Update qualification; a same-register rename overrides the commit clear.
    always_comb begin
        w_ren_ok    = ren_valid && !((ZERO_REG != 0) && (ren_idx == '0));
        w_ren_new   = w_ren_ok && !r_busy[ren_idx];
        w_cmt_hit   = cmt_valid && r_busy[cmt_idx] && (r_tag[cmt_idx] == cmt_tag);
        w_cmt_clr   = w_cmt_hit && !(w_ren_ok && (ren_idx == cmt_idx));
        w_count_nxt = r_busy_count + CNTW'(w_ren_new) - CNTW'(w_cmt_clr);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_busy       <= '0;
            r_tag        <= '0;
            r_busy_count <= '0;
        end else begin
            if (w_cmt_clr) begin
                r_busy[cmt_idx] <= 1'b0;
            end
            if (w_ren_ok) begin
                r_busy[ren_idx] <= 1'b1;
                r_tag[ren_idx]  <= ren_tag;
            end
            r_busy_count <= w_count_nxt;
        end
    end

    assign busy_count = r_busy_count;

    rst_lookup #(.NREG(NREG), .TAGW(TAGW), .ZERO_REG(ZERO_REG)) u_lk_src1 (
        .idx(src1_idx), .busy_vec(r_busy), .tag_vec(r_tag),
        .cmt_valid(cmt_valid), .cmt_idx(cmt_idx), .cmt_tag(cmt_tag),
        .busy(src1_busy), .tag(src1_tag)
    );

    rst_lookup #(.NREG(NREG), .TAGW(TAGW), .ZERO_REG(ZERO_REG)) u_lk_src2 (
        .idx(src2_idx), .busy_vec(r_busy), .tag_vec(r_tag),
        .cmt_valid(cmt_valid), .cmt_idx(cmt_idx), .cmt_tag(cmt_tag),
        .busy(src2_busy), .tag(src2_tag)
    );

    rst_lookup #(.NREG(NREG), .TAGW(TAGW), .ZERO_REG(ZERO_REG)) u_lk_probe (
        .idx(probe_idx), .busy_vec(r_busy), .tag_vec(r_tag),
        .cmt_valid(cmt_valid), .cmt_idx(cmt_idx), .cmt_tag(cmt_tag),
        .busy(probe_busy), .tag(probe_tag)
    );

endmodule
